// File: rtl/cla_pkg.sv
// Shared constants and the group propagate/generate helper for the pipelined CLA.
package cla_pkg;

  localparam int ALU_W = 32;
  localparam int GRP_MAX = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Group P/G over the low n bits; upper bits of the vectors are ignored.
  function automatic pg_t grp_pg(input logic [GRP_MAX-1:0] p,
                                 input logic [GRP_MAX-1:0] g,
                                 input int n);
    pg_t r;
    r.p = 1'b1;
    r.g = 1'b0;
    for (int i = 0; i < GRP_MAX; i++) begin
      if (i < n) begin
        r.g = g[i] | (p[i] & r.g);
        r.p = r.p & p[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SW-bit carry-lookahead slice built from GRP-bit groups.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SW  = 16,
  parameter int GRP = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          pout,
  output logic          gout
);

  localparam int NG = SW / GRP;

  if (GRP > GRP_MAX || GRP < 1 || (SW % GRP) != 0) begin : g_bad_grp
    $error("cla_slice: GRP must divide SW and not exceed GRP_MAX");
  end

  logic [SW-1:0]      p;
  logic [SW-1:0]      g;
  logic [SW-1:0]      c;
  logic [NG-1:0]      gp;
  logic [NG-1:0]      gg;
  logic [NG-1:0]      gc;
  logic [GRP_MAX-1:0] tp;
  logic [GRP_MAX-1:0] tg;
  pg_t                pg;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = '0;
    gg = '0;
    tp = '0;
    tg = '0;
    pg = '0;
    for (int j = 0; j < NG; j++) begin
      tp = '0;
      tg = '0;
      tp[GRP-1:0] = p[j*GRP +: GRP];
      tg[GRP-1:0] = g[j*GRP +: GRP];
      pg    = grp_pg(tp, tg, GRP);
      gp[j] = pg.p;
      gg[j] = pg.g;
    end
  end

  // Every carry is a flat sum-of-products of lower generates, not a ripple chain.
  always_comb begin : p_carry
    logic acc;
    logic pp;
    acc  = 1'b0;
    pp   = 1'b1;
    gc   = '0;
    c    = '0;
    gout = 1'b0;
    for (int j = 0; j <= NG; j++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        acc = acc | (gg[m] & pp);
        pp  = pp & gp[m];
      end
      if (j < NG) gc[j] = acc | (pp & cin);
      else        gout  = acc;
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GRP; i++) begin
        acc = 1'b0;
        pp  = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          acc = acc | (g[j*GRP + m] & pp);
          pp  = pp & p[j*GRP + m];
        end
        c[j*GRP + i] = acc | (pp & gc[j]);
      end
    end
  end

  assign pout = &gp;
  assign cout = gout | (pout & cin);
  assign sum  = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit slice per stage,
// slice carry registered forward, upper operand slices skewed behind it.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = ALU_W,
  parameter int STAGES = 2,
  parameter int GRP    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > 8 || (WIDTH % (STAGES * GRP)) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: need STAGES in 1..8 and WIDTH a multiple of STAGES*GRP");
  end

  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              ovf_q;
  logic              zero_q;

  assign b_eff = (sub == OP_SUB) ? ~b   : b;
  assign c_eff = (sub == OP_SUB) ? ~cin : cin;

  // A stage may load when empty or when its occupant leaves this cycle.
  always_comb begin : p_flow
    logic nxt;
    nxt = out_ready;
    ld  = '0;
    for (int k = LAST; k >= 0; k--) begin
      ld[k] = ~v[k] | nxt;
      nxt   = ld[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_base;
    logic [WIDTH-1:0] s_nxt;
    logic [SW-1:0]    op_a;
    logic [SW-1:0]    op_b;
    logic [SW-1:0]    s;
    logic             ci;
    logic             vin;
    logic             co;
    logic             po;
    logic             go;
    logic             c_out;
    logic             unused_co;
    logic             v_r;
    logic             c_r;
    logic [WIDTH-1:0] s_r;

    if (k == 0) begin : g_in
      assign a_src  = a;
      assign b_src  = b_eff;
      assign ci     = c_eff;
      assign vin    = in_valid;
      assign s_base = '0;
    end else begin : g_mid
      assign a_src  = opa_q[k-1];
      assign b_src  = opb_q[k-1];
      assign ci     = c_q[k-1];
      assign vin    = v[k-1];
      assign s_base = sum_q[k-1];
    end

    assign op_a = a_src[k*SW +: SW];
    assign op_b = b_src[k*SW +: SW];

    cla_slice #(
      .SW  (SW),
      .GRP (GRP)
    ) u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (ci),
      .sum  (s),
      .cout (co),
      .pout (po),
      .gout (go)
    );

    assign c_out     = go | (po & ci);
    assign unused_co = co;

    always_comb begin
      s_nxt = s_base;
      s_nxt[k*SW +: SW] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (ld[k]) begin
        v_r <= vin;
        if (vin) begin
          c_r <= c_out;
          s_r <= s_nxt;
        end
      end
    end

    assign v[k]     = v_r;
    assign c_q[k]   = c_r;
    assign sum_q[k] = s_r;

    if (k < LAST) begin : g_skew
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (ld[k] && vin) begin
          a_r <= a_src;
          b_r <= b_src;
        end
      end
      assign opa_q[k] = a_r;
      assign opb_q[k] = b_r;
    end else begin : g_flags
      assign opa_q[k] = '0;
      assign opb_q[k] = '0;
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (ld[k] && vin) begin
          ovf_q  <= (s[SW-1] ^ op_a[SW-1] ^ op_b[SW-1]) ^ c_out;
          zero_q <= (s_nxt == '0);
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
